ahb_timer_slave: RTL
====================

Name: ahb_timer_slave

Overview:
- AHB-lite responder on the fabric's slave-side signal set (hsel/haddr/hwrite/hwdata in; hready/hresp/hrdata out), alongside the UART and RAM slaves.
- Implements a machine timer: 64-bit mtime with a prescaler, a 64-bit compare register, control/status registers and an interrupt output.
- Supports configurable wait states and the two-cycle ERROR response, so master-side error and stall handling can be exercised.

Parameters:
- ADDR_W, 32, haddr width (matches AHB_ADDR_WIDTH)
- DATA_W, 32, hwdata/hrdata width (matches AHB_DATA_WIDTH); fixed at 32
- PRESCALE, 4, clk cycles per mtime increment; legal range >= 1
- WAIT_STATES, 0, extra hready-low cycles per OKAY transfer; legal range 0..7

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- hsel  input  1  slave select, address phase
- haddr  input  ADDR_W  address, address phase
- hwrite  input  1  1=write, 0=read, address phase
- hwdata  input  DATA_W  write data, data phase
- hready  output  1  transfer done / slave ready
- hresp  output  1  0=OKAY, 1=ERROR
- hrdata  output  DATA_W  read data, valid when hready=1 and hresp=0 in the data phase
- timer_irq  output  1  level interrupt

Behaviour:
- Reset values:
  - Outputs: hready=1, hresp=0, hrdata=0, timer_irq=0.
  - Registers: mtime=0, mtimecmp=all-ones, ctrl=0, pending=0, prescaler=0.
- Register map (offset haddr[4:0]; upper bits are ignored, the fabric decodes the base):
  - 0x00 MTIME_LO, RW
  - 0x04 MTIME_HI, RW
  - 0x08 CMP_LO, RW
  - 0x0C CMP_HI, RW
  - 0x10 CTRL, RW: bit0 en, bit1 irq_en, others read 0
  - 0x14 STATUS: bit0 pending, write-1-to-clear
- Address phase:
  - An address phase is accepted on a clk edge where hsel=1 and hready=1.
  - The slave latches the offset and hwrite, then enters the data phase.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE:
  - Accepted, valid offset, haddr[1:0]=0: go to WAIT if WAIT_STATES>0, else DATA.
  - Accepted, invalid offset (0x18-0x1C) or haddr[1:0]!=0: go to ERR1.
- WAIT:
  - hready=0 for WAIT_STATES cycles, counted by a 3-bit down-counter, then go to DATA.
- DATA:
  - hready=1, hresp=0.
  - Read: hrdata = selected register, registered one cycle earlier so it is stable through the whole data phase.
  - Write: hwdata is committed at the end of this cycle.
  - A new address phase in this cycle is accepted (back-to-back pipelining) and follows the same IDLE decode.
  - Otherwise go to IDLE.
- ERR1: hready=0, hresp=1. Next state ERR2.
- ERR2:
  - hready=1, hresp=1. No register changes, hrdata=0.
  - A new address phase in this cycle is accepted and follows the same IDLE decode; otherwise go to IDLE.
- hsel=0 in IDLE: hready=1, hresp=0.
- Counting:
  - Prescaler counts 0..PRESCALE-1 while ctrl.en=1.
  - At PRESCALE-1 the prescaler wraps to 0 and mtime increments by 1; 64-bit wrap from all-ones to 0.
  - While en=0 both prescaler and mtime hold.
  - Writing CTRL.en from 0 to 1 clears the prescaler.
- Simultaneous events:
  - A bus write to MTIME_LO or MTIME_HI in the same cycle as a tick: the write wins for that half. The other half takes no carry that cycle.
  - STATUS W1C in the same cycle as the match condition being true: set wins, pending stays 1.
- Match and interrupt:
  - match = (mtime >= mtimecmp), 64-bit unsigned compare on registered values.
  - pending is set on any cycle where match=1.
  - timer_irq is registered: it equals pending & irq_en, delayed one cycle.
- Reset mid-transfer: all state returns to reset values immediately; an in-flight transfer is dropped with no partial write.

Decomposition:
- Shared package ahb_pkg holds:
  - HRESP_OKAY/HRESP_ERROR constants
  - register offset constants TMR_MTIME_LO..TMR_STATUS
  - the slave FSM state enum, shared so future slaves reuse it
- Width macros come from const_defines.v.
- One sub-module, ahb_slave_if: the FSM, wait counter, address/write latching and the ERROR sequence. It exports reg_wr, reg_rd, reg_off and reg_wdata strobes.
- ahb_timer_slave instantiates ahb_slave_if and holds the timer registers and compare logic.

Test Plan:
- Write 0x10=0x3 (PRESCALE=4, WAIT_STATES=0), then idle 40 cycles, then read 0x00 -> 10 (±1); hready never low.
- Write CMP_LO=5, CMP_HI=0, then run -> pending=1 and timer_irq=1 within 4*5+2 cycles; write STATUS=1 while the match still holds -> pending remains 1.
- Read 0x18 -> cycle1 hready=0/hresp=1, cycle2 hready=1/hresp=1; read 0x02 -> same sequence; no register changes in either case.
- WAIT_STATES=3, read 0x10 -> exactly 3 hready-low cycles, then hrdata=0x3 with hresp=0.
- Back-to-back: write 0x08=0xA then read 0x08 on consecutive address phases -> read returns 0xA.
- Preload mtime=0xFFFFFFFF_FFFFFFFF with en=1 -> after one prescale period mtime=0. Assert rstn=0 mid-write -> write is discarded and all outputs return to their reset values.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-lite slave definitions: response codes, timer register offsets
// and the slave-side FSM state encoding.
package ahb_pkg;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam int unsigned OFF_W = 5;

  localparam logic [OFF_W-1:0] TMR_MTIME_LO = 5'h00;
  localparam logic [OFF_W-1:0] TMR_MTIME_HI = 5'h04;
  localparam logic [OFF_W-1:0] TMR_CMP_LO   = 5'h08;
  localparam logic [OFF_W-1:0] TMR_CMP_HI   = 5'h0C;
  localparam logic [OFF_W-1:0] TMR_CTRL     = 5'h10;
  localparam logic [OFF_W-1:0] TMR_STATUS   = 5'h14;

  typedef logic [2:0] slv_state_t;

  localparam slv_state_t ST_IDLE = 3'd0;
  localparam slv_state_t ST_WAIT = 3'd1;
  localparam slv_state_t ST_DATA = 3'd2;
  localparam slv_state_t ST_ERR1 = 3'd3;
  localparam slv_state_t ST_ERR2 = 3'd4;

  // Word-aligned and inside the populated part of the register window.
  function automatic logic off_valid(input logic [OFF_W-1:0] off);
    return (off[1:0] == 2'b00) && (off <= TMR_STATUS);
  endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-lite slave front end: address-phase decode, wait-state insertion,
// two-cycle ERROR response and register access strobes.
module ahb_slave_if
  import ahb_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsel_i,
  input  logic [OFF_W-1:0]  haddr_i,
  input  logic              hwrite_i,
  input  logic [DATA_W-1:0] hwdata_i,
  output logic              hready_o,
  output logic              hresp_o,
  output logic              reg_wr_c,
  output logic [OFF_W-1:0]  reg_off_o,
  output logic [DATA_W-1:0] reg_wdata_c,
  output logic              reg_rd_c,
  output logic [OFF_W-1:0]  reg_rd_off_c
);

  localparam logic [2:0] WS_LOAD = 3'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  slv_state_t       state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic             wr_q, wr_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             hready_q, hready_d;
  logic             hresp_q, hresp_d;
  logic             accept;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      off_q    <= '0;
      wr_q     <= 1'b0;
      wcnt_q   <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      off_q    <= off_d;
      wr_q     <= wr_d;
      wcnt_q   <= wcnt_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // IDLE, DATA and ERR2 all drive hready=1 and so share the address-phase decode.
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    wr_d    = wr_q;
    wcnt_d  = wcnt_q;
    accept  = hsel_i & hready_q;
    case (state_q)
      ST_WAIT: begin
        if (wcnt_q == 3'd0) state_d = ST_DATA;
        else                wcnt_d  = wcnt_q - 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          off_d  = haddr_i;
          wr_d   = hwrite_i;
          wcnt_d = WS_LOAD;
          if (!off_valid(haddr_i))  state_d = ST_ERR1;
          else if (WAIT_STATES > 0) state_d = ST_WAIT;
          else                      state_d = ST_DATA;
        end
      end
    endcase
    hready_d = (state_d != ST_WAIT) && (state_d != ST_ERR1);
    hresp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  assign hready_o     = hready_q;
  assign hresp_o      = hresp_q;
  assign reg_wr_c     = (state_q == ST_DATA) && wr_q;
  assign reg_off_o    = off_q;
  assign reg_wdata_c  = hwdata_i;
  // Read data is captured on the edge that enters DATA.
  assign reg_rd_c     = (state_d == ST_DATA) && !wr_d;
  assign reg_rd_off_c = off_d;

endmodule

// File: rtl/ahb_timer_slave.sv
// Machine timer on an AHB-lite slave port: prescaled 64-bit mtime, 64-bit
// compare, sticky pending flag and a registered level interrupt.
module ahb_timer_slave
  import ahb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned PRESCALE    = 4,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              hsel,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hready,
  output logic              hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic              timer_irq
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  logic              reg_wr_c, reg_rd_c;
  logic [OFF_W-1:0]  reg_off, reg_rd_off_c;
  logic [DATA_W-1:0] reg_wdata_c;
  logic              unused_haddr;

  logic [DATA_W-1:0] mtime_lo_q, mtime_lo_d, mtime_hi_q, mtime_hi_d;
  logic [DATA_W-1:0] cmp_lo_q, cmp_lo_d, cmp_hi_q, cmp_hi_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic              pending_q, pending_d;
  logic              irq_q, irq_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [2*DATA_W-1:0] mtime_inc;
  logic              tick, match;
  logic              wr_lo, wr_hi, wr_clo, wr_chi, wr_ctrl, wr_stat;

  assign unused_haddr = ^haddr[ADDR_W-1:OFF_W];

  ahb_slave_if #(
    .DATA_W      (DATA_W),
    .WAIT_STATES (WAIT_STATES)
  ) u_if (
    .clk          (clk),
    .rstn         (rstn),
    .hsel_i       (hsel),
    .haddr_i      (haddr[OFF_W-1:0]),
    .hwrite_i     (hwrite),
    .hwdata_i     (hwdata),
    .hready_o     (hready),
    .hresp_o      (hresp),
    .reg_wr_c     (reg_wr_c),
    .reg_off_o    (reg_off),
    .reg_wdata_c  (reg_wdata_c),
    .reg_rd_c     (reg_rd_c),
    .reg_rd_off_c (reg_rd_off_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mtime_lo_q <= '0;
      mtime_hi_q <= '0;
      cmp_lo_q   <= '1;
      cmp_hi_q   <= '1;
      ctrl_q     <= '0;
      pending_q  <= 1'b0;
      irq_q      <= 1'b0;
      presc_q    <= '0;
      hrdata_q   <= '0;
    end else begin
      mtime_lo_q <= mtime_lo_d;
      mtime_hi_q <= mtime_hi_d;
      cmp_lo_q   <= cmp_lo_d;
      cmp_hi_q   <= cmp_hi_d;
      ctrl_q     <= ctrl_d;
      pending_q  <= pending_d;
      irq_q      <= irq_d;
      presc_q    <= presc_d;
      hrdata_q   <= hrdata_d;
    end
  end

  always_comb begin
    wr_lo   = reg_wr_c && (reg_off == TMR_MTIME_LO);
    wr_hi   = reg_wr_c && (reg_off == TMR_MTIME_HI);
    wr_clo  = reg_wr_c && (reg_off == TMR_CMP_LO);
    wr_chi  = reg_wr_c && (reg_off == TMR_CMP_HI);
    wr_ctrl = reg_wr_c && (reg_off == TMR_CTRL);
    wr_stat = reg_wr_c && (reg_off == TMR_STATUS);

    tick      = ctrl_q[0] && (presc_q == PS_MAX);
    mtime_inc = {mtime_hi_q, mtime_lo_q} + (2*DATA_W)'(1);

    presc_d = presc_q;
    if (ctrl_q[0]) presc_d = tick ? '0 : presc_q + PW'(1);
    if (wr_ctrl && reg_wdata_c[0] && !ctrl_q[0]) presc_d = '0;

    // A bus write owns its half; the other half sees no carry that cycle.
    mtime_lo_d = tick ? mtime_inc[DATA_W-1:0] : mtime_lo_q;
    mtime_hi_d = tick ? mtime_inc[2*DATA_W-1:DATA_W] : mtime_hi_q;
    if (wr_lo) begin
      mtime_lo_d = reg_wdata_c;
      mtime_hi_d = mtime_hi_q;
    end
    if (wr_hi) mtime_hi_d = reg_wdata_c;

    cmp_lo_d = wr_clo ? reg_wdata_c : cmp_lo_q;
    cmp_hi_d = wr_chi ? reg_wdata_c : cmp_hi_q;
    ctrl_d   = wr_ctrl ? reg_wdata_c[1:0] : ctrl_q;

    match     = {mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q};
    pending_d = match | (pending_q & ~(wr_stat & reg_wdata_c[0]));
    irq_d     = pending_q & ctrl_q[1];

    // Muxing next-state values forwards a write that lands on the same edge.
    hrdata_d = '0;
    if (reg_rd_c) begin
      case (reg_rd_off_c)
        TMR_MTIME_LO: hrdata_d = mtime_lo_d;
        TMR_MTIME_HI: hrdata_d = mtime_hi_d;
        TMR_CMP_LO:   hrdata_d = cmp_lo_d;
        TMR_CMP_HI:   hrdata_d = cmp_hi_d;
        TMR_CTRL:     hrdata_d = {(DATA_W-2)'(0), ctrl_d};
        TMR_STATUS:   hrdata_d = {(DATA_W-1)'(0), pending_d};
        default:      hrdata_d = '0;
      endcase
    end
  end

  assign hrdata    = hrdata_q;
  assign timer_irq = irq_q;

endmodule
